cv32e40x_xif_offloader: RTL and testbench
=========================================

CV32E40X_XIF_OFFLOADER -- requirements
Module: cv32e40x_xif_offloader

Interface
REQ-001 SHALL have parameter X_ID_WIDTH, default 4, width of the XIF instruction ID.
REQ-002 SHALL have parameter X_RFR_WIDTH, default 32, width of register-file read and write data.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum number of WAIT_RES cycles before abort.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state on the rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port req_valid_i, input, 1, pipeline offers an instruction for offload.
REQ-007 SHALL have port req_ready_o, output, 1, offloader can take a request.
REQ-008 SHALL have port instr_i, input, 32, instruction word.
REQ-009 SHALL have ports rs1_i and rs2_i, input, X_RFR_WIDTH each, source operands.
REQ-010 SHALL have port kill_i, input, 1, pipeline flush of the in-flight instruction.
REQ-011 SHALL have ports wb_valid_o (1), wb_rd_o (5) and wb_data_o (X_RFR_WIDTH), outputs, a one-cycle register-file writeback.
REQ-012 SHALL have port illegal_o, output, 1, one-cycle pulse when the coprocessor rejects an instruction.
REQ-013 SHALL have port error_o, output, 1, one-cycle pulse on a result-ID mismatch or a timeout.
REQ-014 SHALL have ports xif_issue (if_xif.cpu_issue), xif_commit (if_xif.cpu_commit) and xif_result (if_xif.cpu_result): the CPU end of the issue, commit and result channels.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, COMMIT and WAIT_RES, with exactly one instruction outstanding.
REQ-016 IDLE SHALL drive req_ready_o=1.
- On req_valid_i: latch instr_i, rs1_i, rs2_i and id=id_cnt; clear kill_pend; go to ISSUE.
REQ-017 ISSUE SHALL drive xif_issue.issue_valid=1 with instr, id, rs[0]=rs1, rs[1]=rs2 and rs_valid=3'b011, all held stable until issue_ready.
REQ-018 On issue_valid and issue_ready SHALL:
- latch accept and writeback;
- increment id_cnt modulo 2^X_ID_WIDTH (wraps from all-ones to 0);
- go to COMMIT.
REQ-019 COMMIT SHALL drive commit_valid=1 for exactly one cycle with commit.id=id.
- commit_kill=1 if the instruction was rejected, kill_pend is set, or kill_i is high this cycle.
REQ-020 After COMMIT the FSM SHALL go:
- to WAIT_RES if accepted, writeback=1 and not killed;
- to IDLE otherwise.
- illegal_o pulses 1 in the COMMIT cycle when rejected.
REQ-021 kill_i asserted in ISSUE SHALL set kill_pend; the issue handshake still completes.
REQ-022 kill_i in IDLE SHALL have no effect; kill_i in WAIT_RES SHALL abort to IDLE, and any later result with that id is dropped.
REQ-023 WAIT_RES SHALL drive xif_result.result_ready=1.
- On result_valid with result.id==id: if result.we=1, drive wb_valid_o=1, wb_rd_o=result.rd and wb_data_o=result.data in the next cycle; then go to IDLE.
REQ-024 A result whose id differs from the outstanding id, or any result outside WAIT_RES, SHALL be consumed (result_ready=1) and SHALL pulse error_o; no writeback.
REQ-025 A timeout counter SHALL reset on entry to WAIT_RES; on reaching TIMEOUT_CYCLES it SHALL pulse error_o and go to IDLE.
REQ-026 Issue-to-result latency with an always-ready coprocessor SHALL be: issue in cycle 1, commit in cycle 2, result earliest in cycle 3, writeback in cycle 4.
REQ-027 A kill_i arriving together with issue_ready SHALL yield commit_kill=1.

Reset
REQ-028 On rst_n low, asynchronously:
- FSM=IDLE, id_cnt=0, kill_pend=0, timeout counter=0;
- issue_valid, commit_valid, wb_valid_o, illegal_o and error_o = 0;
- wb_rd_o=0, wb_data_o=0;
- result_ready=0 during reset.
REQ-029 Reset mid-transaction SHALL drop the outstanding instruction without issuing a commit.

Structure
REQ-030 SHALL place the state enum xif_offl_state_e and the XIF opcode constants in cv32e40x_pkg.
REQ-031 SHALL instantiate no sub-modules; the FSM, id counter and timeout counter are local.

Verification
REQ-032 Request instr=AES32, rs1=0x11223344, rs2=0xA5A5A5A5; coprocessor accepts with writeback and returns rd=5, data=0xDEADBEEF -> commit_kill=0, wb_valid_o pulses with wb_rd_o=5 and wb_data_o=0xDEADBEEF.
REQ-033 Coprocessor returns accept=0 -> commit_kill=1, illegal_o is a one-cycle pulse, no writeback, FSM back in IDLE.
REQ-034 kill_i pulsed during ISSUE with issue_ready held low for 3 cycles -> commit_kill=1, no result_ready cycle, no writeback.
REQ-035 17 back-to-back instructions -> ids 0..15 then 0, each commit.id matching its issue id.
REQ-036 Result returned with id=3 while id=2 is outstanding -> error_o pulses, no writeback; a later id=2 result writes back normally.
REQ-037 No result for 255 cycles -> error_o pulses in the 255th WAIT_RES cycle and req_ready_o=1 in the following cycle.

Source files
------------

// File: rtl/cv32e40x_pkg.sv
// Shared types for the X-interface offloader: FSM state encoding and the
// opcode constants used when building offloadable instructions.
package cv32e40x_pkg;

  typedef enum logic [1:0] {
    XIF_IDLE     = 2'd0,
    XIF_ISSUE    = 2'd1,
    XIF_COMMIT   = 2'd2,
    XIF_WAIT_RES = 2'd3
  } xif_offl_state_e;

  localparam logic [6:0] OPCODE_OP       = 7'h33;
  localparam logic [6:0] OPCODE_CUSTOM_0 = 7'h0B;
  localparam logic [6:0] OPCODE_CUSTOM_1 = 7'h2B;

  // aes32esi with bs/rs1/rs2/rd all zero; OR register fields in as needed
  localparam logic [31:0] INSTR_AES32ESI = 32'h2200_0033;

endpackage

// File: rtl/if_xif.sv
// CPU/coprocessor X-interface: issue, commit and result channels.
interface if_xif #(
  parameter int unsigned X_ID_WIDTH  = 4,
  parameter int unsigned X_RFR_WIDTH = 32,
  parameter int unsigned X_NUM_RS    = 2
);

  typedef struct packed {
    logic [31:0]                          instr;
    logic [X_ID_WIDTH-1:0]                id;
    logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0] rs;
    logic [2:0]                           rs_valid;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
  } x_issue_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic                  commit_kill;
  } x_commit_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFR_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
  } x_result_t;

  logic          issue_valid;
  logic          issue_ready;
  x_issue_req_t  issue_req;
  x_issue_resp_t issue_resp;

  logic          commit_valid;
  x_commit_t     commit;

  logic          result_valid;
  logic          result_ready;
  x_result_t     result;

  modport cpu_issue  (output issue_valid, issue_req, input issue_ready, issue_resp);
  modport cpu_commit (output commit_valid, commit);
  modport cpu_result (input result_valid, result, output result_ready);

endinterface

// File: rtl/cv32e40x_xif_offloader.sv
// Single-outstanding X-interface offloader: issues one instruction, commits
// or kills it, then waits (bounded) for its result and writes it back.
module cv32e40x_xif_offloader
  import cv32e40x_pkg::*;
#(
  parameter int unsigned X_ID_WIDTH     = 4,
  parameter int unsigned X_RFR_WIDTH    = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_n,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [31:0]            instr_i,
  input  logic [X_RFR_WIDTH-1:0] rs1_i,
  input  logic [X_RFR_WIDTH-1:0] rs2_i,
  input  logic                   kill_i,
  output logic                   wb_valid_o,
  output logic [4:0]             wb_rd_o,
  output logic [X_RFR_WIDTH-1:0] wb_data_o,
  output logic                   illegal_o,
  output logic                   error_o,
  if_xif.cpu_issue               xif_issue,
  if_xif.cpu_commit              xif_commit,
  if_xif.cpu_result              xif_result
);

  localparam int unsigned  TW       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  xif_offl_state_e        state_q, state_d;
  logic [31:0]            instr_q;
  logic [X_RFR_WIDTH-1:0] rs1_q, rs2_q;
  logic [X_ID_WIDTH-1:0]  id_q, id_cnt_q;
  logic                   kill_pend_q, accept_q, wb_q, alive_q;
  logic [TW-1:0]          tmo_cnt_q;

  logic issue_hs, commit_kill, res_hit, res_stray, tmo_hit;

  assign issue_hs    = (state_q == XIF_ISSUE) && xif_issue.issue_ready;
  assign commit_kill = !accept_q || kill_pend_q || kill_i;
  assign res_hit     = (state_q == XIF_WAIT_RES) && xif_result.result_valid &&
                       (xif_result.result.id == id_q);
  // alive_q keeps result_ready/error low while reset is held
  assign res_stray   = alive_q && xif_result.result_valid && !res_hit;
  assign tmo_hit     = (state_q == XIF_WAIT_RES) && (tmo_cnt_q == TMO_LAST) &&
                       !res_hit && !kill_i;

  assign req_ready_o                  = (state_q == XIF_IDLE);
  assign xif_issue.issue_valid        = (state_q == XIF_ISSUE);
  assign xif_issue.issue_req.instr    = instr_q;
  assign xif_issue.issue_req.id       = id_q;
  assign xif_issue.issue_req.rs       = {rs2_q, rs1_q};
  assign xif_issue.issue_req.rs_valid = 3'b011;

  assign xif_commit.commit_valid       = (state_q == XIF_COMMIT);
  assign xif_commit.commit.id          = id_q;
  assign xif_commit.commit.commit_kill = commit_kill;

  // Results offered outside WAIT_RES are drained so the coprocessor never stalls
  assign xif_result.result_ready = alive_q &&
                                   ((state_q == XIF_WAIT_RES) || xif_result.result_valid);

  assign illegal_o = (state_q == XIF_COMMIT) && !accept_q;
  assign error_o   = res_stray || tmo_hit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      XIF_IDLE:     if (req_valid_i) state_d = XIF_ISSUE;
      XIF_ISSUE:    if (xif_issue.issue_ready) state_d = XIF_COMMIT;
      XIF_COMMIT:   state_d = (accept_q && wb_q && !commit_kill) ? XIF_WAIT_RES : XIF_IDLE;
      XIF_WAIT_RES: if (kill_i || res_hit || tmo_hit) state_d = XIF_IDLE;
      default:      state_d = XIF_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= XIF_IDLE;
      alive_q     <= 1'b0;
      instr_q     <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      id_q        <= '0;
      id_cnt_q    <= '0;
      kill_pend_q <= 1'b0;
      accept_q    <= 1'b0;
      wb_q        <= 1'b0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
      if ((state_q == XIF_IDLE) && req_valid_i) begin
        instr_q     <= instr_i;
        rs1_q       <= rs1_i;
        rs2_q       <= rs2_i;
        id_q        <= id_cnt_q;
        kill_pend_q <= 1'b0;
      end
      // A kill during ISSUE must still reach the commit after the handshake
      if ((state_q == XIF_ISSUE) && kill_i) kill_pend_q <= 1'b1;
      if (issue_hs) begin
        accept_q <= xif_issue.issue_resp.accept;
        wb_q     <= xif_issue.issue_resp.writeback;
        id_cnt_q <= id_cnt_q + 1'b1;
      end
      if (state_q == XIF_COMMIT)        tmo_cnt_q <= '0;
      else if (state_q == XIF_WAIT_RES) tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_o <= 1'b0;
      wb_rd_o    <= '0;
      wb_data_o  <= '0;
    end else begin
      wb_valid_o <= 1'b0;
      if (res_hit && !kill_i && xif_result.result.we) begin
        wb_valid_o <= 1'b1;
        wb_rd_o    <= xif_result.result.rd;
        wb_data_o  <= xif_result.result.data;
      end
    end
  end

endmodule

// File: tb/tb_cv32e40x_xif_offloader.sv
// Directed bench for the XIF offloader: inputs change on the falling edge,
// outputs are checked 1ns later against hand-computed values.
module tb_cv32e40x_xif_offloader;

  localparam logic [31:0] AES_W = 32'h22B5_02B3; // aes32esi x5, x10, x11, bs=0
  localparam int          TMO   = 255;

  logic        clk_i, rst_n;
  logic        req_valid_i, req_ready_o, kill_i;
  logic [31:0] instr_i, rs1_i, rs2_i;
  logic        wb_valid_o, illegal_o, error_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;

  int nchk = 0;
  int nfail = 0;

  if_xif #(.X_ID_WIDTH(4), .X_RFR_WIDTH(32)) xif ();

  cv32e40x_xif_offloader #(.X_ID_WIDTH(4), .X_RFR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .instr_i    (instr_i),
    .rs1_i      (rs1_i),
    .rs2_i      (rs2_i),
    .kill_i     (kill_i),
    .wb_valid_o (wb_valid_o),
    .wb_rd_o    (wb_rd_o),
    .wb_data_o  (wb_data_o),
    .illegal_o  (illegal_o),
    .error_o    (error_o),
    .xif_issue  (xif),
    .xif_commit (xif),
    .xif_result (xif)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk_i);
  endtask

  // IDLE request cycle followed by the first ISSUE cycle
  task automatic req_issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                           input logic rdy, input logic acc, input logic wb, input logic kl);
    cyc();
    req_valid_i = 1'b1; instr_i = ins; rs1_i = a; rs2_i = b; #1;
    chk("req_rdy", req_ready_o, 1);
    cyc();
    req_valid_i = 1'b0; instr_i = '0; kill_i = kl;
    xif.issue_ready = rdy; xif.issue_resp.accept = acc; xif.issue_resp.writeback = wb; #1;
    chk("iss_vld", xif.issue_valid, 1);
  endtask

  task automatic set_res(input logic v, input logic [3:0] id, input logic [4:0] rd,
                         input logic [31:0] d, input logic we);
    xif.result_valid = v; xif.result.id = id; xif.result.rd = rd;
    xif.result.data = d; xif.result.we = we;
  endtask

  initial begin
    logic err;
    logic [3:0] eid;
    clk_i = 0; rst_n = 1; req_valid_i = 0; kill_i = 0;
    instr_i = '0; rs1_i = '0; rs2_i = '0;
    xif.issue_ready = 0; xif.issue_resp = '0; xif.result = '0; xif.result_valid = 1;
    #2 rst_n = 0;
    cyc(); #1;
    chk("rst_req_rdy", req_ready_o, 1);
    chk("rst_iss_vld", xif.issue_valid, 0);
    chk("rst_cmt_vld", xif.commit_valid, 0);
    chk("rst_wb_vld", wb_valid_o, 0);
    chk("rst_wb_rd", wb_rd_o, 0);
    chk("rst_wb_data", wb_data_o, 0);
    chk("rst_illegal", illegal_o, 0);
    chk("rst_error", error_o, 0);
    chk("rst_res_rdy", xif.result_ready, 0);
    cyc(); rst_n = 1; xif.result_valid = 0;

    // accepted AES32 with writeback, id 0
    req_issue(AES_W, 32'h1122_3344, 32'hA5A5_A5A5, 1, 1, 1, 0);
    chk("t1_instr", xif.issue_req.instr, AES_W);
    chk("t1_id", xif.issue_req.id, 0);
    chk("t1_rs0", xif.issue_req.rs[0], 32'h1122_3344);
    chk("t1_rs1", xif.issue_req.rs[1], 32'hA5A5_A5A5);
    chk("t1_rsv", xif.issue_req.rs_valid, 3'b011);
    chk("t1_busy", req_ready_o, 0);
    cyc(); xif.issue_ready = 0; #1;
    chk("t1_cmt_vld", xif.commit_valid, 1);
    chk("t1_cmt_id", xif.commit.id, 0);
    chk("t1_cmt_kill", xif.commit.commit_kill, 0);
    chk("t1_illegal", illegal_o, 0);
    cyc(); set_res(1, 4'd0, 5'd5, 32'hDEAD_BEEF, 1); #1;
    chk("t1_res_rdy", xif.result_ready, 1);
    chk("t1_err", error_o, 0);
    chk("t1_wb_early", wb_valid_o, 0);
    cyc(); xif.result_valid = 0; #1;
    chk("t1_wb_vld", wb_valid_o, 1);
    chk("t1_wb_rd", wb_rd_o, 5);
    chk("t1_wb_data", wb_data_o, 32'hDEAD_BEEF);
    chk("t1_idle", req_ready_o, 1);
    cyc(); #1;
    chk("t1_wb_pulse", wb_valid_o, 0);

    // rejected instruction, id 1
    req_issue(32'h0000_000B, 32'h1, 32'h2, 1, 0, 0, 0);
    chk("t2_id", xif.issue_req.id, 1);
    cyc(); xif.issue_ready = 0; #1;
    chk("t2_cmt_vld", xif.commit_valid, 1);
    chk("t2_cmt_kill", xif.commit.commit_kill, 1);
    chk("t2_illegal", illegal_o, 1);
    cyc(); #1;
    chk("t2_illegal_pulse", illegal_o, 0);
    chk("t2_idle", req_ready_o, 1);
    chk("t2_no_wb", wb_valid_o, 0);

    // stray id=3 result while id=2 outstanding, then the real one
    req_issue(AES_W, 32'h3, 32'h4, 1, 1, 1, 0);
    chk("t3_id", xif.issue_req.id, 2);
    cyc(); xif.issue_ready = 0; #1;
    chk("t3_cmt_kill", xif.commit.commit_kill, 0);
    cyc(); set_res(1, 4'd3, 5'd7, 32'h1234_5678, 1); #1;
    chk("t3_stray_err", error_o, 1);
    chk("t3_stray_rdy", xif.result_ready, 1);
    cyc(); set_res(1, 4'd2, 5'd9, 32'hCAFE_F00D, 1); #1;
    chk("t3_err_clr", error_o, 0);
    chk("t3_no_wb", wb_valid_o, 0);
    cyc(); xif.result_valid = 0; #1;
    chk("t3_wb_vld", wb_valid_o, 1);
    chk("t3_wb_rd", wb_rd_o, 9);
    chk("t3_wb_data", wb_data_o, 32'hCAFE_F00D);

    // kill during ISSUE with issue_ready low for 3 cycles, id 3
    req_issue(AES_W, 32'h5, 32'h6, 0, 1, 1, 1);
    chk("t4_res_rdy0", xif.result_ready, 0);
    cyc(); kill_i = 0; #1;
    chk("t4_hold_vld", xif.issue_valid, 1);
    chk("t4_hold_id", xif.issue_req.id, 3);
    cyc(); #1;
    chk("t4_hold_instr", xif.issue_req.instr, AES_W);
    cyc(); xif.issue_ready = 1; #1;
    cyc(); xif.issue_ready = 0; #1;
    chk("t4_cmt_vld", xif.commit_valid, 1);
    chk("t4_cmt_kill", xif.commit.commit_kill, 1);
    chk("t4_illegal", illegal_o, 0);
    chk("t4_res_rdy1", xif.result_ready, 0);
    cyc(); #1;
    chk("t4_idle", req_ready_o, 1);
    chk("t4_res_rdy2", xif.result_ready, 0);
    chk("t4_no_wb", wb_valid_o, 0);

    // kill coincident with issue_ready, id 4
    req_issue(AES_W, 32'h7, 32'h8, 1, 1, 1, 1);
    cyc(); kill_i = 0; xif.issue_ready = 0; #1;
    chk("t5_cmt_id", xif.commit.id, 4);
    chk("t5_cmt_kill", xif.commit.commit_kill, 1);
    cyc(); #1;
    chk("t5_idle", req_ready_o, 1);

    // kill in WAIT_RES aborts, id 5
    req_issue(AES_W, 32'h9, 32'hA, 1, 1, 1, 0);
    cyc(); xif.issue_ready = 0; #1;
    chk("t6_cmt_kill", xif.commit.commit_kill, 0);
    cyc(); kill_i = 1; #1;
    chk("t6_wait_rdy", xif.result_ready, 1);
    cyc(); kill_i = 0; #1;
    chk("t6_abort", req_ready_o, 1);

    // 17 back-to-back after reset: ids 0..15 then 0
    cyc(); rst_n = 0; #1;
    cyc(); rst_n = 1;
    for (int n = 0; n < 17; n++) begin
      eid = (n < 16) ? 4'(n) : 4'd0;
      req_issue(32'h0000_002B, 32'(n), 32'(n + 1), 1, 1, 0, 0);
      chk($sformatf("b2b_iss_id%0d", n), xif.issue_req.id, eid);
      cyc(); xif.issue_ready = 0; #1;
      chk($sformatf("b2b_cmt_id%0d", n), xif.commit.id, eid);
    end

    // timeout, id 1
    req_issue(AES_W, 32'hB, 32'hC, 1, 1, 1, 0);
    chk("t7_id", xif.issue_req.id, 1);
    cyc(); xif.issue_ready = 0; #1;
    err = 0;
    for (int k = 1; k < TMO; k++) begin
      cyc(); #1;
      err |= error_o;
    end
    chk("t7_early_err", err, 0);
    cyc(); #1;
    chk("t7_err", error_o, 1);
    chk("t7_busy", req_ready_o, 0);
    cyc(); #1;
    chk("t7_idle", req_ready_o, 1);
    chk("t7_err_pulse", error_o, 0);

    // reset mid-transaction drops it without a commit
    req_issue(AES_W, 32'hD, 32'hE, 0, 1, 1, 0);
    cyc(); rst_n = 0; #1;
    chk("t8_iss_vld", xif.issue_valid, 0);
    chk("t8_cmt_vld", xif.commit_valid, 0);
    chk("t8_idle", req_ready_o, 1);
    cyc(); rst_n = 1; #1;
    cyc(); #1;
    chk("t8_no_cmt", xif.commit_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
